// File: rtl/warp_issue_sched.sv
// Warp issue scheduler: tracks per-warp active/stalled/tmask/PC and issues one ready warp per cycle.
// Define WARP_SCHED_RR_EN for round-robin selection; the default build uses fixed lowest-index priority.
module warp_issue_sched #(
  parameter int NUM_WARPS    = 8,
  parameter int NUM_THREADS  = 4,
  parameter int PC_BITS      = 30,
  parameter int NUM_BR_PORTS = 2,
  parameter int NUM_BARRIERS = 4,
  localparam int NW = $clog2(NUM_WARPS),
  localparam int NB = $clog2(NUM_BARRIERS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [PC_BITS-1:0]              startup_pc,
  input  logic                            tmc_valid,
  input  logic [NW-1:0]                   tmc_wid,
  input  logic [NUM_THREADS-1:0]          tmc_tmask,
  input  logic                            wspawn_valid,
  input  logic [NW-1:0]                   wspawn_wid,
  input  logic [NUM_WARPS-1:0]            wspawn_wmask,
  input  logic [PC_BITS-1:0]              wspawn_pc,
  input  logic                            bar_valid,
  input  logic [NW-1:0]                   bar_wid,
  input  logic [NB-1:0]                   bar_id,
  input  logic [NW-1:0]                   bar_size_m1,
  input  logic [NUM_BR_PORTS-1:0]         br_valid,
  input  logic [NUM_BR_PORTS*NW-1:0]      br_wid,
  input  logic [NUM_BR_PORTS-1:0]         br_taken,
  input  logic [NUM_BR_PORTS*PC_BITS-1:0] br_dest,
  input  logic                            unlock_valid,
  input  logic [NW-1:0]                   unlock_wid,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NW-1:0]                   out_wid,
  output logic [NUM_THREADS-1:0]          out_tmask,
  output logic [PC_BITS-1:0]              out_pc,
  output logic [NUM_WARPS-1:0]            active_warps,
  output logic [NUM_WARPS-1:0]            stalled_warps,
  output logic                            busy
);

  logic [NUM_WARPS-1:0]                    active_q, active_d;
  logic [NUM_WARPS-1:0]                    stalled_q, stalled_d;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0]   tmask_q, tmask_d;
  logic [NUM_WARPS-1:0][PC_BITS-1:0]       pc_q, pc_d;
  logic [NUM_BARRIERS-1:0][NW-1:0]         bar_ctr_q, bar_ctr_d;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0]  bar_mask_q, bar_mask_d;

  logic                   out_valid_q;
  logic [NW-1:0]          out_wid_q;
  logic [NUM_THREADS-1:0] out_tmask_q;
  logic [PC_BITS-1:0]     out_pc_q;
  logic                   busy_q;

  logic [NUM_WARPS-1:0]   ready;
  logic [NW-1:0]          sel_wid;
  logic                   select_fire;

  assign ready       = active_q & ~stalled_q;
  assign select_fire = (|ready) & (~out_valid_q | out_ready);

`ifdef WARP_SCHED_RR_EN
  logic [NW-1:0] last_q;

  // Scan downward so the nearest ready warp after last_q is the final assignment.
  always_comb begin
    sel_wid = '0;
    for (int k = NUM_WARPS; k >= 1; k--) begin
      if (ready[last_q + NW'(k)]) sel_wid = last_q + NW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= NW'(NUM_WARPS - 1);
    end else if (select_fire) begin
      last_q <= sel_wid;
    end
  end
`else
  always_comb begin
    sel_wid = '0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      if (ready[k]) sel_wid = NW'(k);
    end
  end
`endif

  // Sources are applied in priority order; later writes override earlier ones.
  always_comb begin
    active_d   = active_q;
    stalled_d  = stalled_q;
    tmask_d    = tmask_q;
    pc_d       = pc_q;
    bar_ctr_d  = bar_ctr_q;
    bar_mask_d = bar_mask_q;

    if (wspawn_valid) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (wspawn_wmask[i] && !active_q[i]) begin
          active_d[i] = 1'b1;
          tmask_d[i]  = NUM_THREADS'(1);
          pc_d[i]     = wspawn_pc;
        end
      end
      stalled_d[wspawn_wid] = 1'b0;
    end

    if (tmc_valid) begin
      tmask_d[tmc_wid]   = tmc_tmask;
      stalled_d[tmc_wid] = 1'b0;
      if (tmc_tmask == '0) active_d[tmc_wid] = 1'b0;
    end

    if (bar_valid) begin
      if (bar_ctr_q[bar_id] == bar_size_m1) begin
        stalled_d          = stalled_d & ~bar_mask_q[bar_id];
        stalled_d[bar_wid] = 1'b0;
        bar_ctr_d[bar_id]  = '0;
        bar_mask_d[bar_id] = '0;
      end else begin
        bar_ctr_d[bar_id]           = bar_ctr_q[bar_id] + NW'(1);
        bar_mask_d[bar_id][bar_wid] = 1'b1;
      end
    end

    for (int p = 0; p < NUM_BR_PORTS; p++) begin
      if (br_valid[p]) begin
        stalled_d[br_wid[p*NW +: NW]] = 1'b0;
        if (br_taken[p]) pc_d[br_wid[p*NW +: NW]] = br_dest[p*PC_BITS +: PC_BITS];
      end
    end

    if (unlock_valid) stalled_d[unlock_wid] = 1'b0;

    if (select_fire) begin
      stalled_d[sel_wid] = 1'b1;
      pc_d[sel_wid]      = pc_q[sel_wid] + PC_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= NUM_WARPS'(1);
      stalled_q   <= '0;
      tmask_q     <= '0;
      tmask_q[0]  <= NUM_THREADS'(1);
      pc_q        <= '0;
      pc_q[0]     <= startup_pc;
      bar_ctr_q   <= '0;
      bar_mask_q  <= '0;
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_tmask_q <= '0;
      out_pc_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      active_q   <= active_d;
      stalled_q  <= stalled_d;
      tmask_q    <= tmask_d;
      pc_q       <= pc_d;
      bar_ctr_q  <= bar_ctr_d;
      bar_mask_q <= bar_mask_d;
      busy_q     <= (|active_q) | out_valid_q;
      if (select_fire) begin
        out_valid_q <= 1'b1;
        out_wid_q   <= sel_wid;
        out_tmask_q <= tmask_q[sel_wid];
        out_pc_q    <= pc_q[sel_wid];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_wid       = out_wid_q;
  assign out_tmask     = out_tmask_q;
  assign out_pc        = out_pc_q;
  assign active_warps  = active_q;
  assign stalled_warps = stalled_q;
  assign busy          = busy_q;

endmodule

// File: doc/warp_issue_sched.md
WARP_ISSUE_SCHED -- requirements
Module: warp_issue_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, number of warps (power of 2, 2..32); NW = log2(NUM_WARPS).
REQ-002 SHALL have parameter NUM_THREADS, default 4, threads per warp.
REQ-003 SHALL have parameter PC_BITS, default 30, PC width.
REQ-004 SHALL have parameter NUM_BR_PORTS, default 2, number of branch resolution ports.
REQ-005 SHALL have parameter NUM_BARRIERS, default 4, number of local barriers (power of 2); NB = log2(NUM_BARRIERS).
REQ-006 SHALL have ports clk, in, 1, clock; reset, in, 1, reset, synchronous, active-high.
REQ-007 SHALL have port startup_pc, in, PC_BITS, warp 0 PC loaded at reset.
REQ-008 SHALL have ports tmc_valid, in, 1; tmc_wid, in, NW; tmc_tmask, in, NUM_THREADS; these carry a thread-mask change.
REQ-009 SHALL have ports wspawn_valid, in, 1; wspawn_wid, in, NW (spawning warp); wspawn_wmask, in, NUM_WARPS; wspawn_pc, in, PC_BITS.
REQ-010 SHALL have ports bar_valid, in, 1; bar_wid, in, NW; bar_id, in, NB; bar_size_m1, in, NW (participating warps minus 1).
REQ-011 SHALL have ports br_valid, in, NUM_BR_PORTS; br_wid, in, NUM_BR_PORTS*NW; br_taken, in, NUM_BR_PORTS; br_dest, in, NUM_BR_PORTS*PC_BITS.
REQ-012 SHALL have ports unlock_valid, in, 1; unlock_wid, in, NW; these carry the decode-stage release of a non-control instruction.
REQ-013 SHALL have ports out_valid, out, 1; out_ready, in, 1; out_wid, out, NW; out_tmask, out, NUM_THREADS; out_pc, out, PC_BITS.
REQ-014 SHALL have ports active_warps, out, NUM_WARPS; stalled_warps, out, NUM_WARPS; busy, out, 1.

Function
REQ-015 SHALL hold per-warp state: active bit, stalled bit, tmask, PC; ready = active & ~stalled.
REQ-016 SHALL select one ready warp per cycle when the output register is empty or out_ready=1 (select_fire); selection policy per REQ-032/033.
REQ-017 On select_fire SHALL load the output register with {wid, tmask, PC} and set out_valid the next cycle; the latency from ready to out_valid is 1 cycle.
REQ-018 On select_fire SHALL set the warp's stalled bit and advance its PC by 1 (mod 2^PC_BITS, wrapping silently).
REQ-019 out_valid SHALL clear only after a cycle with out_valid&out_ready and no select_fire; output fields SHALL be stable while out_valid&~out_ready.
REQ-020 TMC SHALL set tmask[tmc_wid]=tmc_tmask and clear stalled; a tmask of 0 SHALL also clear active.
REQ-021 wspawn SHALL, for each wmask bit i whose warp is inactive, set active, tmask=1 (thread 0), and PC=wspawn_pc. Already-active warps SHALL be untouched. SHALL clear stalled[wspawn_wid].
REQ-022 On barrier arrival with ctr[id]==size_m1, SHALL clear stalled for mask[id] and bar_wid, then reset ctr[id] and mask[id] to 0. Otherwise SHALL increment ctr[id], set mask[id][bar_wid], and leave the warp stalled.
REQ-023 bar_size_m1=0 SHALL release the arriving warp in the same update.
REQ-024 A branch on port p SHALL clear stalled[br_wid]. If taken, it SHALL also set PC=br_dest. When several ports target the same warp, the highest index SHALL win.
REQ-025 unlock_valid SHALL clear stalled[unlock_wid].
REQ-026 Within a cycle, updates SHALL apply in this order: wspawn, TMC, barrier, branch, unlock, select_fire stall-set (last wins).
REQ-027 busy SHALL be (active_warps!=0)|out_valid, registered with 1-cycle delay.

Reset
REQ-028 On reset SHALL clear all active/stalled/tmask/PC/barrier counters and masks, and clear out_valid.
REQ-029 On reset SHALL set active[0]=1, tmask[0]=1 (thread 0 only), and PC[0]=startup_pc; busy SHALL reset to 0.
REQ-030 Reset asserted mid-operation SHALL drop any pending output without handshake and discard barrier state.
REQ-031 SHALL schedule warp 0 on the first cycle after reset deasserts.

Configuration
REQ-032 With WARP_SCHED_RR_EN defined, SHALL select the first ready warp at index > last granted wid, wrapping modulo NUM_WARPS; the last-granted pointer SHALL reset to NUM_WARPS-1.
REQ-033 Without WARP_SCHED_RR_EN, SHALL select the lowest-index ready warp (fixed priority) and SHALL contain no pointer register.

Verification
REQ-034 Reset with startup_pc=0x100, out_ready=1 -> cycle 1: out_valid=1, wid=0, pc=0x100, tmask=0001; no further output until unlock_valid wid=0.
REQ-035 wspawn wmask=0x0E pc=0x200 from warp 0, RR build, out_ready=1, unlocks each cycle -> wids issued in order 1,2,3,0,1, each new warp at pc 0x200.
REQ-036 out_ready=0 for 5 cycles with out_valid=1 -> out_wid/pc unchanged, no PC advance, then one transfer when out_ready=1.
REQ-037 Barrier id=2 size_m1=2: warps 1,2 arrive -> both stay stalled; warp 3 arrives -> warps 1,2,3 unlocked the next cycle, ctr[2]=0.
REQ-038 Same-cycle br port0 (wid 1, dest 0x40) and port1 (wid 1, dest 0x80), both taken -> PC[1]=0x80; tmc wid=1 tmask=0 -> active[1]=0, busy drops after the pipeline drains.
